// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute unit: one-cycle logic/arith/compare ops and a bit-serial
// shifter (one bit per cycle) behind a valid/ready request and result interface.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] CtrlAnd  = 4'b0000;
    localparam logic [3:0] CtrlOr   = 4'b0001;
    localparam logic [3:0] CtrlAdd  = 4'b0010;
    localparam logic [3:0] CtrlSub  = 4'b0110;
    localparam logic [3:0] CtrlSll  = 4'b0011;
    localparam logic [3:0] CtrlSrl  = 4'b0100;
    localparam logic [3:0] CtrlSlt  = 4'b0111;
    localparam logic [3:0] CtrlSltu = 4'b1011;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] sum, diff, alu_res, shifted;
    logic             alu_ovf, alu_ill, is_shift;

    // Single-cycle datapath, evaluated on the live request inputs.
    always_comb begin
        sum      = op_a + op_b;
        diff     = op_a - op_b;
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (alu_ctrl)
            CtrlAnd: alu_res = op_a & op_b;
            CtrlOr:  alu_res = op_a | op_b;
            CtrlAdd: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            CtrlSub: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            CtrlSll, CtrlSrl: begin
                alu_res  = op_b;
                is_shift = 1'b1;
            end
            CtrlSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CtrlSltu: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default:  alu_ill = 1'b1;
        endcase
    end

    assign shifted = left_q ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        shreg_d = op_b;
                        cnt_d   = shamt;
                        left_d  = (alu_ctrl == CtrlSll);
                        state_d = StShift;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        ill_d    = alu_ill;
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - 5'd1;
                // The edge performing the last shift also publishes the result.
                if (cnt_q == 5'd1) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int n_total = 0;
    int n_bad   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on signed/unsigned integers.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] s, output logic [31:0] r, output logic ov,
                                  output logic il, output int lat);
        longint sa;
        longint sb;
        longint t;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        ov  = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                t  = sa + sb;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd6: begin
                t  = sa - sb;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd3: begin
                r   = b << s;
                lat = int'(s) + 1;
            end
            4'd4: begin
                r   = b >> s;
                lat = int'(s) + 1;
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd11: r = (a < b) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        shamt    = 5'($urandom);
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s, input int hold);
        logic [31:0] er;
        logic        eo;
        logic        ei;
        int          elat;
        int          lat;
        bit          got;
        model(c, a, b, s, er, eo, ei, elat);
        check_val("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        shamt    = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1;
            else begin
                check_val("in_ready_busy", in_ready, 0);
                scramble_inputs();
            end
        end
        check_val("latency", lat, elat);
        check_val("result", result, er);
        check_val("zero", zero, (er == 32'd0));
        check_val("overflow", overflow, eo);
        check_val("illegal", illegal, ei);
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_result", result, er);
            check_val("hold_flags", {zero, overflow, illegal}, {(er == 32'd0), eo, ei});
            check_val("hold_in_ready", in_ready, 0);
        end
        // Drain with a request pending: it must not be taken on the drain edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_ctrl  = 4'b0000;
        @(negedge clk);
        check_val("drain_valid", out_valid, 0);
        check_val("drain_in_ready", in_ready, 1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    logic [3:0] legal_codes [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd3, 4'd4, 4'd7, 4'd11};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = '0;
        op_a      = '0;
        op_b      = '0;
        shamt     = '0;
        #1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_outputs", {result, zero, overflow, illegal}, 35'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
        run_op(4'b0110, 32'h0000_1234, 32'h0000_1234, 5'd0, 1);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0);
        run_op(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0);
        run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, 0);
        run_op(4'b0011, 32'h0, 32'h0000_0001, 5'd31, 0);
        run_op(4'b0100, 32'h0, 32'h8000_0000, 5'd4, 0);
        run_op(4'b0011, 32'h0, 32'hDEAD_BEEF, 5'd0, 0);
        run_op(4'b0100, 32'h0, 32'h0000_0001, 5'd1, 2);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 10);

        // Reset mid-shift: first pass watches for stray pulses, second restarts at once.
        for (int pass = 0; pass < 2; pass++) begin
            in_valid = 1'b1;
            alu_ctrl = 4'b0011;
            op_b     = 32'h0000_0003;
            shamt    = 5'd20;
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (7) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check_val("midrst_out_valid", out_valid, 0);
            check_val("midrst_in_ready", in_ready, 1);
            check_val("midrst_outputs", {result, zero, overflow, illegal}, 35'd0);
            @(negedge clk);
            rst_n = 1'b1;
            if (pass == 0) begin
                for (int i = 0; i < 25; i++) begin
                    @(negedge clk);
                    check_val("post_rst_quiet", {out_valid, in_ready}, 2'b01);
                end
            end
        end
        run_op(4'b0000, 32'h0000_00FF, 32'h0000_0F0F, 5'd0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = b;
                1: b = 32'h8000_0000 ^ a;
                default: ;
            endcase
            run_op(c, a, b, 5'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
